// File: rtl/blocpu_pkg.sv
// Shared definitions for the BloCPU program loader: FSM state encoding and
// the per-state core-control/status flag decode.
package blocpu_pkg;

   localparam int CYCLE_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ARMED,
      ST_RUN,
      ST_DONE
   } loader_state_t;

   typedef struct packed {
      logic core_reset;
      logic core_running;
      logic busy;
      logic done;
   } loader_flags_t;

   localparam loader_flags_t FLAGS_RESET = '{core_reset: 1'b1, core_running: 1'b0,
                                             busy: 1'b0, done: 1'b0};

   // The core is held in reset everywhere except RUN, so it never sees a half-written image.
   function automatic loader_flags_t state_flags(input loader_state_t st);
      loader_flags_t f;
      f              = FLAGS_RESET;
      f.core_reset   = (st != ST_RUN);
      f.core_running = (st == ST_RUN);
      f.busy         = (st == ST_LOAD) || (st == ST_RUN);
      f.done         = (st == ST_DONE);
      return f;
   endfunction

endpackage

// File: rtl/blocpu_sat_counter.sv
// Clearable up-counter that sticks at its all-ones value instead of wrapping.
module blocpu_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      return (v == {WIDTH{1'b1}}) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= sat_inc(count);
      end
   end

endmodule

// File: rtl/blocpu_program_loader.sv
// BloCPU program loader: streams an image into instruction memory, then runs the core.
// Define BLOCPU_LOADER_TIMEOUT_EN to enable the run watchdog (TIMEOUT_CYCLES).
module blocpu_program_loader
   import blocpu_pkg::*;
#(
   parameter int INSTR_WIDTH    = 12,
   parameter int DEPTH          = 256,
   parameter int TIMEOUT_CYCLES = 65535,
   localparam int ADDR_W        = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_valid,
   input  logic [INSTR_WIDTH-1:0] load_data,
   input  logic                   load_last,
   output logic                   load_ready,
   input  logic                   start,
   output logic                   imem_we,
   output logic [ADDR_W-1:0]      imem_addr,
   output logic [INSTR_WIDTH-1:0] imem_wdata,
   output logic                   core_reset,
   output logic                   core_running,
   input  logic                   core_halt,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout,
   output logic [ADDR_W:0]        load_count,
   output logic [CYCLE_W-1:0]     cycle_count
);

`ifdef BLOCPU_LOADER_TIMEOUT_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif

   localparam logic [ADDR_W:0]    DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [CYCLE_W-1:0] WDOG_LAST = CYCLE_W'(TIMEOUT_CYCLES - 1);

   loader_state_t state;
   loader_flags_t flags;
   logic          timeout_q;
   logic          accept;
   logic          fill;
   logic          run_launch;
   logic          wdog_hit;
   logic [ADDR_W:0] cnt_next;

   // IDLE and DONE both (re)start an image at address 0.
   assign load_ready = (state == ST_IDLE) || (state == ST_DONE) ||
                       ((state == ST_LOAD) && (load_count < DEPTH_L));
   assign accept     = load_valid && load_ready;
   assign cnt_next   = (state == ST_LOAD) ? load_count + 1'b1 : (ADDR_W+1)'(1);
   assign fill       = load_last || (cnt_next == DEPTH_L);
   assign run_launch = start && ((state == ST_ARMED) || ((state == ST_DONE) && !load_valid));
   // Fires on the last RUN cycle so RUN lasts exactly TIMEOUT_CYCLES cycles.
   assign wdog_hit   = WDOG_EN && (cycle_count >= WDOG_LAST);

   assign imem_we    = accept;
   assign imem_addr  = (state == ST_LOAD) ? load_count[ADDR_W-1:0] : '0;
   assign imem_wdata = accept ? load_data : '0;

   assign core_reset   = flags.core_reset;
   assign core_running = flags.core_running;
   assign busy         = flags.busy;
   assign done         = flags.done;
   assign timeout      = timeout_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         flags      <= state_flags(ST_IDLE);
         load_count <= '0;
         timeout_q  <= 1'b0;
      end else if (state == ST_RUN) begin
         if (core_halt) begin
            state <= ST_DONE;
            flags <= state_flags(ST_DONE);
         end else if (wdog_hit) begin
            state     <= ST_DONE;
            flags     <= state_flags(ST_DONE);
            timeout_q <= 1'b1;
         end
      end else if (accept) begin
         load_count <= cnt_next;
         timeout_q  <= 1'b0;
         state      <= fill ? ST_ARMED : ST_LOAD;
         flags      <= state_flags(fill ? ST_ARMED : ST_LOAD);
      end else if (run_launch) begin
         timeout_q <= 1'b0;
         state     <= ST_RUN;
         flags     <= state_flags(ST_RUN);
      end
   end

   blocpu_sat_counter #(
      .WIDTH(CYCLE_W)
   ) u_cycle_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (run_launch),
      .en   (state == ST_RUN),
      .count(cycle_count)
   );

endmodule

// File: tb/tb_blocpu_program_loader.sv
// Directed bench for blocpu_program_loader; write-port traffic is checked against a queue of expected writes.
module tb_blocpu_program_loader;

   localparam int IW = 12;

   typedef struct {
      logic [7:0]    addr;
      logic [IW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          load_valid, load_last, load_ready, start, imem_we;
   logic          core_reset, core_running, core_halt, busy, done, timeout;
   logic [IW-1:0] load_data, imem_wdata;
   logic [7:0]    imem_addr;
   logic [8:0]    load_count;
   logic [31:0]   cycle_count;

   logic          s_load_valid, s_load_last, s_load_ready, s_start, s_imem_we;
   logic          s_core_reset, s_core_running, s_core_halt, s_busy, s_done, s_timeout;
   logic [IW-1:0] s_load_data, s_imem_wdata;
   logic [1:0]    s_imem_addr;
   logic [2:0]    s_load_count;
   logic [31:0]   s_cycle_count;

   int  tests = 0;
   int  fails = 0;
   int  run_cycles;
   wr_t q[$];
   wr_t qs[$];
   logic [IW-1:0] prog [8] = '{12'h82A, 12'h901, 12'h441, 12'hA01,
                               12'h312, 12'hEFF, 12'hFFF, 12'h306};

   blocpu_program_loader #(
      .INSTR_WIDTH(IW), .DEPTH(256), .TIMEOUT_CYCLES(100)
   ) u_dut (
      .clk(clk), .reset(reset),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready), .start(start),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_reset(core_reset), .core_running(core_running), .core_halt(core_halt),
      .busy(busy), .done(done), .timeout(timeout),
      .load_count(load_count), .cycle_count(cycle_count)
   );

   blocpu_program_loader #(
      .INSTR_WIDTH(IW), .DEPTH(4), .TIMEOUT_CYCLES(100)
   ) u_small (
      .clk(clk), .reset(reset),
      .load_valid(s_load_valid), .load_data(s_load_data), .load_last(s_load_last),
      .load_ready(s_load_ready), .start(s_start),
      .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
      .core_reset(s_core_reset), .core_running(s_core_running), .core_halt(s_core_halt),
      .busy(s_busy), .done(s_done), .timeout(s_timeout),
      .load_count(s_load_count), .cycle_count(s_cycle_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : mon_main
      wr_t e;
      if (imem_we === 1'b1) begin
         tests++;
         assert (q.size() != 0) else begin
            fails++;
            $error("FAIL wr_unexpected: observed write addr %0h data %0h expected no write", imem_addr, imem_wdata);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            check("wr_addr", 64'(imem_addr), 64'(e.addr));
            check("wr_data", 64'(imem_wdata), 64'(e.data));
         end
      end
   end

   always @(negedge clk) begin : mon_small
      wr_t e;
      if (s_imem_we === 1'b1) begin
         tests++;
         assert (qs.size() != 0) else begin
            fails++;
            $error("FAIL s_wr_unexpected: observed write addr %0h data %0h expected no write", s_imem_addr, s_imem_wdata);
         end
         if (qs.size() != 0) begin
            e = qs.pop_front();
            check("s_wr_addr", 64'(s_imem_addr), 64'(e.addr));
            check("s_wr_data", 64'(s_imem_wdata), 64'(e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: observed no finish expected finish within budget");
      $fatal(1, "bench time limit");
   end

   initial begin
      reset = 1'b1;
      load_valid = 0; load_last = 0; load_data = '0; start = 0; core_halt = 0;
      s_load_valid = 0; s_load_last = 0; s_load_data = '0; s_start = 0; s_core_halt = 0;

      @(negedge clk);
      check("rst_load_ready", 64'(load_ready), 1);
      check("rst_imem_we", 64'(imem_we), 0);
      check("rst_imem_addr", 64'(imem_addr), 0);
      check("rst_imem_wdata", 64'(imem_wdata), 0);
      check("rst_core_reset", 64'(core_reset), 1);
      check("rst_core_running", 64'(core_running), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done), 0);
      check("rst_timeout", 64'(timeout), 0);
      check("rst_load_count", 64'(load_count), 0);
      check("rst_cycle_count", 64'(cycle_count), 0);

      tick();
      reset = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      check("start_idle_ignored", 64'(core_running), 0);

      // Load the 8-word image; a start pulse mid-load must be ignored.
      tick();
      for (int i = 0; i < 8; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = (i == 7);
         start      = (i == 3);
         q.push_back('{addr: 8'(i), data: prog[i]});
         tick();
         start = 1'b0;
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      @(negedge clk);
      check("armed_load_count", 64'(load_count), 8);
      check("armed_load_ready", 64'(load_ready), 0);
      check("armed_busy", 64'(busy), 0);
      check("armed_core_reset", 64'(core_reset), 1);
      check("armed_not_running", 64'(core_running), 0);

      tick();
      core_halt = 1'b1;
      tick();
      core_halt = 1'b0;
      @(negedge clk);
      check("halt_armed_ignored", 64'(done), 0);

      // Run, halting in the 20th RUN cycle.
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      run_cycles = 0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 20) core_halt = 1'b1;
         @(negedge clk);
         if (core_running === 1'b1) run_cycles++;
         if (k == 1) check("run_core_reset", 64'(core_reset), 0);
         if (k == 5) check("run_cycle_mid", 64'(cycle_count), 4);
         if (k == 5) check("run_busy", 64'(busy), 1);
         tick();
      end
      core_halt = 1'b0;
      @(negedge clk);
      check("run_cycles", 64'(run_cycles), 20);
      check("done_flag", 64'(done), 1);
      check("done_cycle_count", 64'(cycle_count), 20);
      check("done_core_reset", 64'(core_reset), 1);
      check("done_not_running", 64'(core_running), 0);
      repeat (3) @(negedge clk);
      check("done_cycle_frozen", 64'(cycle_count), 20);

      // Re-run the same image from DONE.
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         if (k == 3) core_halt = 1'b1;
         @(negedge clk);
         if (k == 1) check("rerun_running", 64'(core_running), 1);
         if (k == 1) check("rerun_done_clr", 64'(done), 0);
         tick();
      end
      core_halt = 1'b0;
      @(negedge clk);
      check("rerun_cycle_count", 64'(cycle_count), 3);
      check("rerun_done", 64'(done), 1);

      // start and load_valid together in DONE: the load wins.
      tick();
      start      = 1'b1;
      load_valid = 1'b1;
      load_data  = 12'h5A5;
      load_last  = 1'b0;
      q.push_back('{addr: 8'd0, data: 12'h5A5});
      tick();
      start     = 1'b0;
      load_data = 12'h3C3;
      load_last = 1'b1;
      q.push_back('{addr: 8'd1, data: 12'h3C3});
      @(negedge clk);
      check("reload_busy", 64'(busy), 1);
      check("reload_not_running", 64'(core_running), 0);
      check("reload_done_clr", 64'(done), 0);
      check("reload_count1", 64'(load_count), 1);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      @(negedge clk);
      check("reload_count2", 64'(load_count), 2);
      check("reload_armed", 64'(busy), 0);

      // Reset in the middle of a run.
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      check("pre_rst_running", 64'(core_running), 1);
      tick();
      reset = 1'b1;
      #1;
      check("midrst_running", 64'(core_running), 0);
      check("midrst_core_reset", 64'(core_reset), 1);
      check("midrst_busy", 64'(busy), 0);
      check("midrst_done", 64'(done), 0);
      check("midrst_cycle_count", 64'(cycle_count), 0);
      check("midrst_load_count", 64'(load_count), 0);
      check("midrst_load_ready", 64'(load_ready), 1);
      tick();
      reset     = 1'b0;
      start     = 1'b1;
      core_halt = 1'b1;
      tick();
      start     = 1'b0;
      core_halt = 1'b0;
      @(negedge clk);
      check("postrst_start_ignored", 64'(core_running), 0);
      check("postrst_halt_ignored", 64'(done), 0);

      // DEPTH=4 instance: six words, no last, must stop at four without wrapping.
      tick();
      for (int i = 0; i < 6; i++) begin
         s_load_valid = 1'b1;
         s_load_data  = IW'(12'h100 + i);
         if (i < 4) qs.push_back('{addr: 8'(i), data: IW'(12'h100 + i)});
         @(negedge clk);
         if (i >= 4) check("s_ready_full", 64'(s_load_ready), 0);
         tick();
      end
      s_load_valid = 1'b0;
      @(negedge clk);
      check("s_load_count", 64'(s_load_count), 4);
      check("s_armed_busy", 64'(s_busy), 0);
      check("s_core_reset", 64'(s_core_reset), 1);

`ifdef BLOCPU_LOADER_TIMEOUT_EN
      tick();
      load_valid = 1'b1;
      load_data  = 12'h777;
      load_last  = 1'b1;
      q.push_back('{addr: 8'd0, data: 12'h777});
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      run_cycles = 0;
      for (int k = 0; k < 300 && done !== 1'b1; k++) begin
         @(negedge clk);
         if (core_running === 1'b1) run_cycles++;
      end
      check("wdog_done", 64'(done), 1);
      check("wdog_run_cycles", 64'(run_cycles), 100);
      check("wdog_timeout", 64'(timeout), 1);
      check("wdog_cycle_count", 64'(cycle_count), 100);

      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      run_cycles = 0;
      for (int k = 1; k <= 100; k++) begin
         if (k == 100) core_halt = 1'b1;
         @(negedge clk);
         if (k == 1) check("wdog_rerun_timeout_clr", 64'(timeout), 0);
         if (core_running === 1'b1) run_cycles++;
         tick();
      end
      core_halt = 1'b0;
      @(negedge clk);
      check("halt_wins_done", 64'(done), 1);
      check("halt_wins_timeout", 64'(timeout), 0);
      check("halt_wins_cycles", 64'(run_cycles), 100);
`else
      check("timeout_tied_low", 64'(timeout), 0);
`endif

      check("wr_queue_drained", 64'(q.size()), 0);
      check("s_wr_queue_drained", 64'(qs.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/blocpu_program_loader.md
BLOCPU_PROGRAM_LOADER -- requirements
Module: blocpu_program_loader

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 12, instruction word width.
REQ-002 SHALL have parameter DEPTH, default 256, instruction memory words; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, run-cycle limit (used only with REQ-030 macro).
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports load_valid in 1, load_data in INSTR_WIDTH, load_last in 1, load_ready out 1  program word stream.
REQ-007 SHALL have port start  in  1  one-cycle pulse launching the loaded program.
REQ-008 SHALL have ports imem_we out 1, imem_addr out ADDR_W, imem_wdata out INSTR_WIDTH  instruction memory write port.
REQ-009 SHALL have ports core_reset out 1, core_running out 1, core_halt in 1  core control; core_halt high = core stopped itself.
REQ-010 SHALL have ports busy out 1, done out 1, timeout out 1, load_count out ADDR_W+1, cycle_count out 32  status.

Function
REQ-011 SHALL implement states IDLE, LOAD, ARMED, RUN, DONE.
REQ-012 IDLE: load_valid high SHALL enter LOAD with write address 0, accepting that word in the same cycle.
REQ-013 Word accepted iff load_valid && load_ready; SHALL drive imem_we=1, imem_addr=current address, imem_wdata=load_data combinationally in that cycle.
REQ-014 Address and load_count SHALL increment by 1 per accepted word; load_ready SHALL be high in IDLE/LOAD while load_count < DEPTH.
REQ-015 Full (load_count == DEPTH): load_ready SHALL be 0; further words stall, never wrap to address 0.
REQ-016 Accepted word with load_last=1, or reaching full, SHALL move to ARMED next cycle.
REQ-017 start in IDLE or LOAD SHALL be ignored; start in ARMED SHALL enter RUN next cycle.
REQ-018 core_reset SHALL be 1 in IDLE, LOAD, ARMED, DONE and 0 in RUN; core_running SHALL be 1 only in RUN.
REQ-019 RUN: cycle_count SHALL clear on entry and increment by 1 per cycle, saturating at 2^32-1.
REQ-020 RUN: core_halt high SHALL move to DONE next cycle; cycle_count freezes at that value.
REQ-021 DONE: done SHALL be 1; start SHALL re-run the same image (back to RUN, no reload); load_valid SHALL restart loading at address 0 (LOAD, done cleared).
REQ-022 start and load_valid simultaneous in DONE: load SHALL win, start ignored.
REQ-023 busy SHALL be 1 in LOAD and RUN, 0 otherwise.
REQ-024 core_halt outside RUN SHALL be ignored.

Reset
REQ-025 reset assertion SHALL immediately force IDLE, regardless of state (mid-load, mid-run).
REQ-026 Reset values: load_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, core_running=0, busy=0, done=0, timeout=0, load_count=0, cycle_count=0.
REQ-027 Memory contents SHALL not be cleared by reset; a new load is required after reset.
REQ-028 First state transition after deassertion SHALL occur no earlier than the first rising clk edge.

Configuration
REQ-029 Macro BLOCPU_LOADER_TIMEOUT_EN SHALL select the watchdog.
REQ-030 Defined: RUN with cycle_count reaching TIMEOUT_CYCLES SHALL go to DONE with timeout=1 (sticky until next load/start/reset); absent: no watchdog, timeout tied 0, RUN lasts until core_halt.
REQ-031 core_halt and timeout in same cycle SHALL give DONE with timeout=0 (halt wins).

Structure
REQ-032 State enum and status-flag constants SHALL live in shared package blocpu_pkg.
REQ-033 Cycle counter with saturation SHALL be sub-module blocpu_sat_counter; remainder is one FSM module.

Verification
REQ-034 Load 8 words 0x82A,0x901,0x441,0xA01,0x312,0xEFF,0xFFF,0x306, last on 8th -> 8 writes to addr 0..7, load_count=8, state ARMED.
REQ-035 start, core_halt after 20 cycles -> core_running high 20 cycles, done=1, cycle_count=20, core_reset back to 1.
REQ-036 DEPTH=4, stream 6 words no last -> 4 writes, load_ready=0 after 4th, ARMED, no write to addr 0 again.
REQ-037 reset pulse mid-RUN -> core_running=0, core_reset=1, all status zero same cycle; start after reset ignored.
REQ-038 BLOCPU_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100, core never halts -> DONE after 100 cycles, timeout=1; repeat with halt on cycle 100 -> timeout=0.
REQ-039 In DONE assert start and load_valid together -> LOAD entered, address 0 written, core_running stays 0.
